// File: rtl/ps2_tx_multi.sv
// Multi-channel PS/2 device-side transmitter, one byte FIFO per channel.
// Optional host-inhibit handling is enabled with macro PS2_INHIBIT_EN.
module ps2_tx_multi #(
  parameter int CHANNELS  = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 100
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [7:0]          wr_data,
  input  logic [CHANNELS-1:0] wr_strobe,
  input  logic                flush,
  input  logic [CHANNELS-1:0] ps2_inhibit,
  output logic [CHANNELS-1:0] ps2_clk,
  output logic [CHANNELS-1:0] ps2_data,
  output logic [CHANNELS-1:0] fifo_full,
  output logic [CHANNELS-1:0] fifo_empty,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overflow
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam logic [15:0] DIV_MAX = 16'(PS2DIV);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_PAR  = 4'd9;
  localparam logic [3:0] ST_STOP = 4'd10;
  localparam logic [3:0] ST_END  = 4'd11;

  logic [15:0] div_q;
  logic        phase_q;
  logic        tick;

  assign tick = (div_q == DIV_MAX) && !phase_q;

  // Shared divider and phase bit; tick marks the 0->1 phase toggle
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else if (div_q == DIV_MAX) begin
      div_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      div_q <= div_q + 16'd1;
    end
  end

`ifndef PS2_INHIBIT_EN
  logic unused_inh;
  assign unused_inh = ^ps2_inhibit;
`endif

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [7:0]       mem [DEPTH];
    logic [FIFO_BITS:0] wp_q, rp_q;
    logic             full, empty, push, pop;
    logic             ovf_q;
    logic [3:0]       st_q, st_d;
    logic [7:0]       sh_q, sh_d;
    logic             par_q, par_d;
    logic             dat_q, dat_d;
    logic             inh;
    logic             clk_o, busy_o;

`ifdef PS2_INHIBIT_EN
    assign inh = ps2_inhibit[n];
`else
    assign inh = 1'b0;
`endif

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[FIFO_BITS-1:0] == rp_q[FIFO_BITS-1:0])
                && (wp_q[FIFO_BITS] != rp_q[FIFO_BITS]);
    assign push  = reset_n && wr_strobe[n] && !full && !flush;

    // Byte storage; contents are meaningless outside the pointer window
    always_ff @(posedge clk_sys) begin
      if (push) mem[wp_q[FIFO_BITS-1:0]] <= wr_data;
    end

    // FIFO pointers and sticky overflow; flush wins over push and pop
    always_ff @(posedge clk_sys) begin
      if (!reset_n || flush) begin
        wp_q  <= '0;
        rp_q  <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop) rp_q <= rp_q + 1'b1;
        if (wr_strobe[n] && full) ovf_q <= 1'b1;
      end
    end

    // Frame state register
    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        st_q  <= ST_IDLE;
        sh_q  <= '0;
        par_q <= 1'b0;
        dat_q <= 1'b1;
      end else begin
        st_q  <= st_d;
        sh_q  <= sh_d;
        par_q <= par_d;
        dat_q <= dat_d;
      end
    end

    // Next-state: shift one frame bit out per tick
    always_comb begin
      st_d  = st_q;
      sh_d  = sh_q;
      par_d = par_q;
      dat_d = dat_q;
      pop   = 1'b0;
      if (inh && st_q != ST_IDLE && st_q != ST_END) begin
        st_d  = ST_IDLE;
        dat_d = 1'b1;
      end else if (tick) begin
        unique case (1'b1)
          (st_q == ST_IDLE): begin
            if (!empty && !inh) begin
              sh_d  = mem[rp_q[FIFO_BITS-1:0]];
              dat_d = 1'b0;
              par_d = 1'b1;
              st_d  = 4'd1;
            end
          end
          (st_q >= 4'd1 && st_q <= 4'd8): begin
            dat_d = sh_q[0];
            par_d = par_q ^ sh_q[0];
            sh_d  = sh_q >> 1;
            st_d  = st_q + 4'd1;
          end
          (st_q == ST_PAR): begin
            dat_d = par_q;
            st_d  = ST_STOP;
          end
          (st_q == ST_STOP): begin
            dat_d = 1'b1;
            st_d  = ST_END;
          end
          (st_q == ST_END): begin
            pop   = !empty;
            dat_d = 1'b1;
            st_d  = ST_IDLE;
          end
          default: begin
            dat_d = 1'b1;
            st_d  = ST_IDLE;
          end
        endcase
      end
    end

    // Outputs: clock idles high, low half only while a frame runs
    always_comb begin
      clk_o  = phase_q || (st_q == ST_IDLE);
      busy_o = (st_q != ST_IDLE);
    end

    assign ps2_clk[n]    = clk_o;
    assign busy[n]       = busy_o;
    assign ps2_data[n]   = dat_q;
    assign fifo_full[n]  = full;
    assign fifo_empty[n] = empty;
    assign overflow[n]   = ovf_q;
  end

endmodule

// File: tb/tb_ps2_tx_multi.sv
// Bench for ps2_tx_multi: directed frames plus random traffic
// against a frame-level model; honours PS2_INHIBIT_EN.
module tb_ps2_tx_multi;

  localparam int CH  = 2;
  localparam int FB  = 3;
  localparam int DIV = 2;
  localparam int CAP = 1 << FB;
  localparam int PER = 2 * (DIV + 1);

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    wr_data = '0;
  logic [CH-1:0] wr_strobe = '0;
  logic          flush = 1'b0;
  logic [CH-1:0] ps2_inhibit = '0;
  logic [CH-1:0] ps2_clk, ps2_data, fifo_full;
  logic [CH-1:0] fifo_empty, busy, overflow;

  int checks = 0;
  int passed = 0;

  always #5 clk_sys = ~clk_sys;

  ps2_tx_multi #(
    .CHANNELS(CH), .FIFO_BITS(FB), .PS2DIV(DIV)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .wr_data(wr_data), .wr_strobe(wr_strobe),
    .flush(flush), .ps2_inhibit(ps2_inhibit),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: actual %0h required %0h",
                  nm, $time, act, exp);
  endtask

  // Model: edges since reset, queue per channel, frame position
  int         e = 0;
  bit         mstarted = 0;
  int         pos [CH];
  logic [10:0] fr [CH];
  logic [7:0] mq [CH][CAP];
  int         head [CH];
  int         cnt [CH];
  bit         ovf [CH];

  // Frame bit k is sent at the k-th tick: start, LSB-first, odd parity, stop
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic model_step();
    bit tk, inh, full, dopop;
    if (!reset_n) begin
      e = 0;
      for (int c = 0; c < CH; c++) begin
        pos[c] = 0; head[c] = 0; cnt[c] = 0; ovf[c] = 0;
      end
      return;
    end
    e++;
    tk = ((e % PER) == DIV + 1);
    for (int c = 0; c < CH; c++) begin
`ifdef PS2_INHIBIT_EN
      inh = ps2_inhibit[c];
`else
      inh = 0;
`endif
      full = (cnt[c] == CAP);
      dopop = 0;
      if (inh && pos[c] >= 1 && pos[c] <= 10) pos[c] = 0;
      else if (tk) begin
        if (pos[c] == 0) begin
          if (cnt[c] > 0 && !inh) begin
            fr[c] = frame_of(mq[c][head[c]]);
            pos[c] = 1;
          end
        end else if (pos[c] == 11) begin
          dopop = (cnt[c] > 0);
          pos[c] = 0;
        end else pos[c]++;
      end
      if (flush) begin
        cnt[c] = 0; head[c] = 0; ovf[c] = 0;
      end else begin
        if (dopop) begin
          head[c] = (head[c] + 1) % CAP;
          cnt[c]--;
        end
        if (wr_strobe[c]) begin
          if (!full) begin
            mq[c][(head[c] + cnt[c]) % CAP] = wr_data;
            cnt[c]++;
          end else ovf[c] = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk_sys);
    model_step();
    mstarted = 1;
  end

  // Every-cycle compare against the model
  initial forever begin
    @(negedge clk_sys);
    if (mstarted) begin
      for (int c = 0; c < CH; c++) begin
        logic ph, xd;
        ph = ((e / (DIV + 1)) % 2) == 1;
        xd = (pos[c] == 0) ? 1'b1 : fr[c][pos[c] - 1];
        chk("m_clk", ps2_clk[c], ph || pos[c] == 0);
        chk("m_data", ps2_data[c], xd);
        chk("m_busy", busy[c], pos[c] != 0);
        chk("m_empty", fifo_empty[c], cnt[c] == 0);
        chk("m_full", fifo_full[c], cnt[c] == CAP);
        chk("m_ovf", overflow[c], ovf[c]);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic write(input logic [CH-1:0] s, input logic [7:0] d);
    wr_strobe = s;
    wr_data = d;
    @(negedge clk_sys);
    wr_strobe = '0;
  endtask

  task automatic wait_busy(input int c, input logic v);
    int n = 0;
    while (busy[c] !== v && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    chk("wait_busy", busy[c], v);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy !== '0 || fifo_empty !== '1) && n < lim) begin
      @(negedge clk_sys);
      n++;
    end
    chk("idle", {busy, fifo_empty}, {2'b00, 2'b11});
  endtask

  task automatic sample_frame(input int c, input logic [10:0] seq,
                              input string nm);
    int lows;
    wait_busy(c, 1'b1);
    for (int k = 0; k < 11; k++) begin
      chk(nm, ps2_data[c], seq[k]);
      lows = 0;
      for (int j = 0; j < PER; j++) begin
        @(negedge clk_sys);
        if (ps2_clk[c] == 1'b0) lows++;
      end
      if (k == 0) chk("clk_low", lows, DIV + 1);
    end
  endtask

  initial begin
    logic [10:0] s1c, s55;
    s1c = 11'b100_0011_1000;
    s55 = 11'b110_1010_1010;

    // Reset values
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("rst_clk", ps2_clk, 2'b11);
    chk("rst_data", ps2_data, 2'b11);
    chk("rst_empty", fifo_empty, 2'b11);
    chk("rst_full", fifo_full, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_ovf", overflow, 2'b00);
    reset_n = 1'b1;

    // Single byte 0x1C
    write(2'b01, 8'h1C);
    sample_frame(0, s1c, "f1c");
    chk("f1c_empty", fifo_empty[0], 1'b1);
    chk("f1c_busy", busy[0], 1'b0);

    // Overflow: 9 writes, eight kept
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("ovf_full", fifo_full[0], 1'b1);
      write(2'b01, 8'(8'h31 + i * 7));
    end
    chk("ovf_flag", overflow[0], 1'b1);
    wait_idle(1500);

    // Two channels start on the same tick
    do_reset();
    write(2'b01, 8'hAA);
    write(2'b10, 8'hFF);
    wait_busy(0, 1'b1);
    chk("same_tick", busy, 2'b11);
    repeat (9 * PER) @(negedge clk_sys);
    chk("parity2", ps2_data, 2'b11);
    wait_idle(200);

    // Flush during frame 1 state 5
    do_reset();
    write(2'b01, 8'h11);
    write(2'b01, 8'h22);
    write(2'b01, 8'h33);
    wait_busy(0, 1'b1);
    repeat (4 * PER) @(negedge clk_sys);
    flush = 1'b1;
    @(negedge clk_sys);
    flush = 1'b0;
    chk("fl_busy", busy[0], 1'b1);
    wait_busy(0, 1'b0);
    chk("fl_ovf", overflow[0], 1'b0);
    chk("fl_empty", fifo_empty[0], 1'b1);
    repeat (5 * PER) @(negedge clk_sys);
    chk("fl_quiet", busy[0], 1'b0);

    // Reset mid-frame at state 6
    do_reset();
    write(2'b01, 8'h3C);
    wait_busy(0, 1'b1);
    repeat (5 * PER) @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("mr_clk", ps2_clk, 2'b11);
    chk("mr_data", ps2_data, 2'b11);
    chk("mr_busy", busy, 2'b00);
    chk("mr_empty", fifo_empty, 2'b11);
    reset_n = 1'b1;

`ifdef PS2_INHIBIT_EN
    // Inhibit at state 4 aborts, byte resent after release
    write(2'b01, 8'h55);
    wait_busy(0, 1'b1);
    repeat (3 * PER) @(negedge clk_sys);
    ps2_inhibit[0] = 1'b1;
    @(negedge clk_sys);
    chk("inh_busy", busy[0], 1'b0);
    chk("inh_data", ps2_data[0], 1'b1);
    repeat (19) @(negedge clk_sys);
    chk("inh_held", fifo_empty[0], 1'b0);
    ps2_inhibit[0] = 1'b0;
    sample_frame(0, s55, "f55");
    chk("f55_empty", fifo_empty[0], 1'b1);
`else
    // Inhibit ignored: frame runs through
    write(2'b01, 8'h55);
    wait_busy(0, 1'b1);
    ps2_inhibit = 2'b11;
    @(negedge clk_sys);
    chk("noinh_busy", busy[0], 1'b1);
    ps2_inhibit = '0;
    wait_idle(200);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      reset_n = ($urandom_range(0, 1499) != 0);
      flush = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) begin
        wr_strobe = CH'($urandom_range(1, (1 << CH) - 1));
        wr_data = 8'($urandom);
      end else wr_strobe = '0;
      for (int c = 0; c < CH; c++) begin
        if (ps2_inhibit[c]) begin
          if ($urandom_range(0, 19) == 0) ps2_inhibit[c] = 1'b0;
        end else if ($urandom_range(0, 149) == 0) ps2_inhibit[c] = 1'b1;
      end
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    flush = 1'b0;
    wr_strobe = '0;
    ps2_inhibit = '0;
    wait_idle(3000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
